// File: rtl/ioctl_pkg.sv
// Shared types and sizing helpers for the ioctl download engine.
package ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ioctl_word_slot.sv
// One-word register (valid/addr/data/be) with whole-word load and clear.
// load_i wins over clear_i so a slot can be emptied and refilled on one edge.
module ioctl_word_slot
  import ioctl_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [BE_W-1:0]   be_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;

  // NOTE: <= so every register here samples pre-edge values; the datapath is
  // reset as well because it drives outputs that must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
      be_q    <= be_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule

// File: rtl/ioctl_loader.sv
// ioctl byte stream -> packed DATA_W words routed to one of NUM_TGT targets.
// A hold slot packs bytes; an out slot presents the finished word to the target.
module ioctl_loader
  import ioctl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int NUM_TGT    = 4,
  parameter int INDEX_BASE = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  output logic                    mem_req,
  input  logic                    mem_ready,
  output logic [NUM_TGT-1:0]      mem_sel,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic                    core_reset,
  output logic                    done,
  output logic                    err
);

  localparam int BYTES  = bytes_of(DATA_W);
  localparam int LB     = lb_of(DATA_W);
  localparam int LANE_W = (LB > 0) ? LB : 1;

  state_e state_q, state_d;
  logic [7:0] tgt_q;
  logic       tgt_bad_q, core_reset_q, done_q, err_q;
  logic       in_load, in_drain, session_start, session_end;

  logic              hold_v, out_v;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data, new_data;
  logic [BYTES-1:0]  hold_be, new_be;

  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        idx_off;
  logic              idx_bad, addr_hi_err, byte_err, accept, jump, flush, out_clear;

  assign lane        = LANE_W'(ioctl_addr & IOCTL_ADDR_W'(BYTES - 1));
  assign waddr       = ADDR_W'(ioctl_addr >> LB);
  assign addr_hi_err = (ioctl_addr >> (LB + ADDR_W)) != '0;
  assign idx_off     = ioctl_index - 8'(INDEX_BASE);
  assign idx_bad     = (ioctl_index < 8'(INDEX_BASE)) || (int'(idx_off) >= NUM_TGT);

  // Only register outputs feed the stall, so the host never sees an input loop.
  assign ioctl_wait = out_v & hold_v;
  assign byte_err   = in_load & ioctl_wr & (ioctl_wait | tgt_bad_q | addr_hi_err);
  assign accept     = in_load & ioctl_wr & ~byte_err;
  assign jump       = accept & hold_v & (hold_addr != waddr);
  assign flush      = hold_v & (~out_v | mem_ready) & ((&hold_be) | jump | in_drain);
  assign out_clear  = out_v & mem_ready;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    new_data = '0;
    new_be   = '0;
    if (hold_v && !flush) begin
      new_data = hold_data;
      new_be   = hold_be;
    end
    new_data[8*int'(lane) +: 8] = ioctl_dout;
    new_be[lane]                = 1'b1;
  end

  ioctl_word_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BYTES)) u_hold (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .load_i  (accept),
    .clear_i (flush),
    .addr_i  (waddr),
    .data_i  (new_data),
    .be_i    (new_be),
    .valid_o (hold_v),
    .addr_o  (hold_addr),
    .data_o  (hold_data),
    .be_o    (hold_be)
  );

  ioctl_word_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BYTES)) u_out (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .load_i  (flush),
    .clear_i (out_clear),
    .addr_i  (hold_addr),
    .data_i  (hold_data),
    .be_i    (hold_be),
    .valid_o (out_v),
    .addr_o  (mem_addr),
    .data_o  (mem_data),
    .be_o    (mem_be)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ioctl_download) state_d = LOAD;
      LOAD:    if (!ioctl_download) state_d = DRAIN;
      DRAIN:   if (!hold_v && !out_v) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_load       = (state_q == LOAD);
    in_drain      = (state_q == DRAIN);
    session_start = (state_q == IDLE) && ioctl_download;
    session_end   = in_drain && !hold_v && !out_v;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q        <= '0;
      tgt_bad_q    <= 1'b0;
      core_reset_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= session_end;
      if (session_start) begin
        tgt_q        <= idx_off;
        tgt_bad_q    <= idx_bad;
        core_reset_q <= 1'b1;
        err_q        <= 1'b0;
      end else begin
        if (session_end) core_reset_q <= 1'b0;
        if (byte_err)    err_q        <= 1'b1;
      end
    end
  end

  assign mem_req    = out_v;
  assign mem_sel    = out_v ? (NUM_TGT'(1) << tgt_q) : '0;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
